// File: rtl/fmul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier for any binary format, with a valid/ready
// handshake, per-beat rounding mode, gradual underflow and an opaque tag carried alongside.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [1:0]             in_rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_res,
    output logic [4:0]             out_flags,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 3;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] SH_MAX = EW'(MAN_W + 3);
    localparam logic signed [EW-1:0] ONE    = EW'(1);
    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;

    function automatic logic round_up(input logic [1:0] rm, input logic sign,
                                      input logic lsb, input logic g, input logic r,
                                      input logic s);
        logic inc;
        case (rm)
            RM_RNE:  inc = g & (r | s | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & (g | r | s);
            default: inc = sign & (g | r | s);
        endcase
        return inc;
    endfunction

    // Overflow goes to Inf unless the rounding direction points back toward zero.
    function automatic logic [DW-1:0] sat_overflow(input logic [1:0] rm, input logic sign);
        logic to_inf;
        to_inf = (rm == RM_RNE) || (rm == RM_RUP && !sign) || (rm == 2'd3 && sign);
        if (to_inf)
            return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        return {sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    endfunction

    function automatic logic signed [EW-1:0] lzc(input logic [PW-1:0] v);
        logic signed [EW-1:0] n;
        logic found;
        n = '0;
        found = 1'b0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (!found && !v[i])
                n = n + ONE;
            else
                found = 1'b1;
        end
        return n;
    endfunction

    logic stall, adv;
    logic out_valid_q;

    assign stall    = out_valid_q & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    // ---- S1: unpack, classify, add exponents ----
    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [EW-1:0]   ea_x, eb_x;

    logic                   vld_p1_d, sign_p1_d, spec_p1_d;
    logic [DW-1:0]          spec_res_p1_d;
    logic [4:0]             spec_flags_p1_d;
    logic [MW-1:0]          ma_p1_d, mb_p1_d;
    logic signed [EW-1:0]   exp_p1_d;

    logic                   vld_p1_q, sign_p1_q, spec_p1_q;
    logic [DW-1:0]          spec_res_p1_q;
    logic [4:0]             spec_flags_p1_q;
    logic [MW-1:0]          ma_p1_q, mb_p1_q;
    logic signed [EW-1:0]   exp_p1_q;
    logic [1:0]             rm_p1_q;
    logic [TAG_W-1:0]       tag_p1_q;

    assign {sa, ea, fa} = in_a;
    assign {sb, eb, fb} = in_b;

    always_comb begin
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_zero = (ea == '0) && (fa == '0);
        b_zero = (eb == '0) && (fb == '0);

        vld_p1_d        = in_valid;
        sign_p1_d       = sa ^ sb;
        spec_p1_d       = 1'b1;
        spec_res_p1_d   = '0;
        spec_flags_p1_d = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_res_p1_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            spec_flags_p1_d = 5'b00100;
        end else if (a_inf || b_inf) begin
            spec_res_p1_d   = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_res_p1_d   = {sa ^ sb, {(DW - 1){1'b0}}};
            spec_flags_p1_d = 5'b00001;
        end else begin
            spec_p1_d       = 1'b0;
        end

        // Subnormals: hidden bit 0, exponent pinned to 1-bias.
        ma_p1_d  = {ea != '0, fa};
        mb_p1_d  = {eb != '0, fb};
        ea_x     = (ea == '0) ? ONE : $signed({3'b000, ea});
        eb_x     = (eb == '0) ? ONE : $signed({3'b000, eb});
        exp_p1_d = ea_x + eb_x - BIAS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (adv) begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p1_q       <= sign_p1_d;
            spec_p1_q       <= spec_p1_d;
            spec_res_p1_q   <= spec_res_p1_d;
            spec_flags_p1_q <= spec_flags_p1_d;
            ma_p1_q         <= ma_p1_d;
            mb_p1_q         <= mb_p1_d;
            exp_p1_q        <= exp_p1_d;
            rm_p1_q         <= in_rm;
            tag_p1_q        <= in_tag;
        end
    end

    // ---- S2: mantissa product ----
    logic [PW-1:0]          prod_p2_d;
    logic                   vld_p2_q, sign_p2_q, spec_p2_q;
    logic [DW-1:0]          spec_res_p2_q;
    logic [4:0]             spec_flags_p2_q;
    logic [PW-1:0]          prod_p2_q;
    logic signed [EW-1:0]   exp_p2_q;
    logic [1:0]             rm_p2_q;
    logic [TAG_W-1:0]       tag_p2_q;

    always_comb begin
        prod_p2_d = PW'(ma_p1_q) * PW'(mb_p1_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
        end else if (adv) begin
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p2_q       <= sign_p1_q;
            spec_p2_q       <= spec_p1_q;
            spec_res_p2_q   <= spec_res_p1_q;
            spec_flags_p2_q <= spec_flags_p1_q;
            prod_p2_q       <= prod_p2_d;
            exp_p2_q        <= exp_p1_q;
            rm_p2_q         <= rm_p1_q;
            tag_p2_q        <= tag_p1_q;
        end
    end

    // ---- S3: normalise, denormalise, round, pack, flags ----
    logic signed [EW-1:0]   lz, e_norm, sh, e_pre, e_post;
    logic [PW-1:0]          norm, shifted;
    logic                   tiny, lost, g, r, s, inc, inexact, ovf;
    logic [MW-1:0]          mant;
    logic [MW:0]            mant_r;
    logic [MAN_W-1:0]       frac;
    logic [DW-1:0]          out_res_d, out_res_q;
    logic [4:0]             out_flags_d, out_flags_q;
    logic [TAG_W-1:0]       out_tag_q;

    always_comb begin
        lz      = lzc(prod_p2_q);
        e_norm  = exp_p2_q + ONE - lz;
        norm    = prod_p2_q << lz;
        tiny    = (e_norm < ONE);
        sh      = ONE - e_norm;
        shifted = norm;
        lost    = 1'b0;
        if (tiny) begin
            if (sh >= SH_MAX) begin
                shifted = '0;
                lost    = |norm;
            end else begin
                shifted = norm >> sh;
                lost    = |(norm & ~({PW{1'b1}} << sh));
            end
        end

        mant   = shifted[PW-1:MW];
        g      = shifted[MW-1];
        r      = shifted[MW-2];
        s      = (|shifted[MW-3:0]) | lost;
        inc    = round_up(rm_p2_q, sign_p2_q, mant[0], g, r, s);
        mant_r = {1'b0, mant} + (MW + 1)'(inc);

        // A carry out of the hidden bit bumps the exponent; a subnormal that
        // rounds up into the hidden bit becomes the minimum normal.
        e_pre  = tiny ? '0 : e_norm;
        e_post = e_pre;
        frac   = mant_r[MAN_W-1:0];
        if (mant_r[MW]) begin
            e_post = e_pre + ONE;
            frac   = mant_r[MAN_W:1];
        end else if (tiny && mant_r[MAN_W]) begin
            e_post = ONE;
        end

        inexact = g | r | s;
        ovf     = (e_post >= EMAX);

        if (spec_p2_q) begin
            out_res_d   = spec_res_p2_q;
            out_flags_d = spec_flags_p2_q;
        end else if (ovf) begin
            out_res_d   = sat_overflow(rm_p2_q, sign_p2_q);
            out_flags_d = 5'b10010;
        end else begin
            out_res_d   = {sign_p2_q, e_post[EXP_W-1:0], frac};
            out_flags_d = {1'b0, tiny & inexact, 1'b0, inexact, e_post == '0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= vld_p2_q;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
            out_tag_q   <= tag_p2_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_flags = out_flags_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: single- and half-precision vector tables,
// plus backpressure ordering and mid-stream reset sequences.
module tb_fmul_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sp_in_valid, sp_in_ready, sp_out_valid, sp_out_ready;
    logic [31:0] sp_a, sp_b, sp_res;
    logic [1:0]  sp_rm;
    logic [3:0]  sp_tag, sp_out_tag;
    logic [4:0]  sp_flags;

    logic        hp_in_valid, hp_in_ready, hp_out_valid, hp_out_ready;
    logic [15:0] hp_a, hp_b, hp_res;
    logic [1:0]  hp_rm;
    logic [3:0]  hp_tag, hp_out_tag;
    logic [4:0]  hp_flags;

    fmul_pipe u_sp (
        .clk(clk), .rst(rst),
        .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .in_a(sp_a), .in_b(sp_b), .in_rm(sp_rm), .in_tag(sp_tag),
        .out_valid(sp_out_valid), .out_ready(sp_out_ready),
        .out_res(sp_res), .out_flags(sp_flags), .out_tag(sp_out_tag)
    );

    fmul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_hp (
        .clk(clk), .rst(rst),
        .in_valid(hp_in_valid), .in_ready(hp_in_ready),
        .in_a(hp_a), .in_b(hp_b), .in_rm(hp_rm), .in_tag(hp_tag),
        .out_valid(hp_out_valid), .out_ready(hp_out_ready),
        .out_res(hp_res), .out_flags(hp_flags), .out_tag(hp_out_tag)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        half;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] res;
        logic [4:0]  flags;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_vec(input vec_t v, input logic [3:0] tag);
        int lat;
        logic [31:0] res;
        logic [4:0] flags;
        logic [3:0] otag;
        @(negedge clk);
        if (v.half) begin
            hp_in_valid = 1'b1; hp_a = v.a[15:0]; hp_b = v.b[15:0]; hp_rm = v.rm; hp_tag = tag;
        end else begin
            sp_in_valid = 1'b1; sp_a = v.a; sp_b = v.b; sp_rm = v.rm; sp_tag = tag;
        end
        @(posedge clk);
        #1;
        sp_in_valid = 1'b0;
        hp_in_valid = 1'b0;
        lat = 1;
        while (!(v.half ? hp_out_valid : sp_out_valid) && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res   = v.half ? {16'h0, hp_res} : sp_res;
        flags = v.half ? hp_flags : sp_flags;
        otag  = v.half ? hp_out_tag : sp_out_tag;
        chk({v.name, "_lat"}, lat, 32'd3);
        chk(v.name, res, v.res);
        chk({v.name, "_flags"}, {27'h0, flags}, {27'h0, v.flags});
        chk({v.name, "_tag"}, {28'h0, otag}, {28'h0, tag});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, got, cyc, stale, extra;
        logic acc, ret, hold;
        logic [31:0] held_res;
        logic [3:0] held_tag;

        rst = 1'b1;
        sp_in_valid = 0; sp_out_ready = 1; sp_a = 0; sp_b = 0; sp_rm = 0; sp_tag = 0;
        hp_in_valid = 0; hp_out_ready = 1; hp_a = 0; hp_b = 0; hp_rm = 0; hp_tag = 0;

        vecs.push_back('{1'b0, 32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, "mul_1p5x2"});
        vecs.push_back('{1'b0, 32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 5'b10010, "ovf_rne"});
        vecs.push_back('{1'b0, 32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 5'b10010, "ovf_rtz"});
        vecs.push_back('{1'b0, 32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 5'b10010, "ovf_neg_up"});
        vecs.push_back('{1'b0, 32'hFF7FFFFF, 32'h40000000, 2'd3, 32'hFF800000, 5'b10010, "ovf_neg_dn"});
        vecs.push_back('{1'b0, 32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b00100, "inf_x_zero"});
        vecs.push_back('{1'b0, 32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b00100, "nan_in"});
        vecs.push_back('{1'b0, 32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 5'b00000, "inf_x_fin"});
        vecs.push_back('{1'b0, 32'h80000000, 32'h3F800000, 2'd0, 32'h80000000, 5'b00001, "zero_x_fin"});
        vecs.push_back('{1'b0, 32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 5'b00001, "sub_exact"});
        vecs.push_back('{1'b0, 32'h007FFFFF, 32'h3F800001, 2'd0, 32'h00800000, 5'b01010, "sub_to_norm"});
        vecs.push_back('{1'b0, 32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 5'b00010, "inx_rne"});
        vecs.push_back('{1'b0, 32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 5'b00010, "inx_up"});
        vecs.push_back('{1'b0, 32'hBF800001, 32'h3F800001, 2'd3, 32'hBF800003, 5'b00010, "inx_neg_dn"});
        vecs.push_back('{1'b0, 32'hBF800001, 32'h3F800001, 2'd1, 32'hBF800002, 5'b00010, "inx_neg_rtz"});
        vecs.push_back('{1'b0, 32'h3F800001, 32'h3FC00000, 2'd0, 32'h3FC00002, 5'b00010, "tie_odd_rne"});
        vecs.push_back('{1'b0, 32'h3F800001, 32'h3FC00000, 2'd1, 32'h3FC00001, 5'b00010, "tie_odd_rtz"});
        vecs.push_back('{1'b0, 32'h00000001, 32'h3F000000, 2'd1, 32'h00000000, 5'b01011, "uflow_rtz"});
        vecs.push_back('{1'b0, 32'h00000001, 32'h3F000000, 2'd2, 32'h00000001, 5'b01011, "uflow_up"});
        vecs.push_back('{1'b0, 32'h00000001, 32'h00000001, 2'd2, 32'h00000001, 5'b01011, "deep_sticky_up"});
        vecs.push_back('{1'b0, 32'h00000001, 32'h00000001, 2'd0, 32'h00000000, 5'b01011, "deep_sticky_rne"});
        vecs.push_back('{1'b1, 32'h00003C00, 32'h00003C00, 2'd0, 32'h00003C00, 5'b00000, "hp_one"});
        vecs.push_back('{1'b1, 32'h00000001, 32'h00003800, 2'd0, 32'h00000000, 5'b01011, "hp_uflow_rne"});
        vecs.push_back('{1'b1, 32'h00000001, 32'h00003800, 2'd2, 32'h00000001, 5'b01011, "hp_uflow_up"});
        vecs.push_back('{1'b1, 32'h00007BFF, 32'h00004000, 2'd0, 32'h00007C00, 5'b10010, "hp_ovf"});

        #2;
        chk("rst_out_valid", {31'h0, sp_out_valid}, 32'd0);
        chk("rst_out_res", sp_res, 32'd0);
        chk("rst_out_flags", {27'h0, sp_flags}, 32'd0);
        chk("rst_out_tag", {28'h0, sp_out_tag}, 32'd0);
        chk("rst_in_ready", {31'h0, sp_in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i], 4'(i));

        // Backpressure: 8 tagged beats, random out_ready, results in order and held while stalled.
        sent = 0; got = 0; cyc = 0; hold = 1'b0; held_res = '0; held_tag = '0;
        while (got < 8 && cyc < 300) begin
            @(negedge clk);
            sp_out_ready = 1'($urandom_range(0, 1));
            sp_in_valid  = (sent < 8);
            sp_a   = 32'h3F800000;
            sp_b   = 32'h40000000 | (32'(sent) << 20);
            sp_rm  = 2'd0;
            sp_tag = 4'(sent);
            #1;
            if (hold) begin
                chk("hold_valid", {31'h0, sp_out_valid}, 32'd1);
                chk("hold_res", sp_res, held_res);
                chk("hold_tag", {28'h0, sp_out_tag}, {28'h0, held_tag});
            end
            acc = sp_in_valid && sp_in_ready;
            ret = sp_out_valid && sp_out_ready;
            hold = sp_out_valid && !sp_out_ready;
            held_res = sp_res;
            held_tag = sp_out_tag;
            if (ret) begin
                chk("bp_tag", {28'h0, sp_out_tag}, 32'(got));
                chk("bp_res", sp_res, 32'h40000000 | (32'(got) << 20));
                got++;
            end
            if (acc) sent++;
            cyc++;
        end
        chk("bp_count", 32'(got), 32'd8);
        sp_in_valid = 1'b0;
        sp_out_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (sp_out_valid) extra++;
        end
        chk("bp_no_dup", 32'(extra), 32'd0);

        // Reset in the middle of a full pipeline.
        @(negedge clk);
        sp_out_ready = 1'b1; sp_in_valid = 1'b1;
        sp_a = 32'h3F800000; sp_b = 32'h40000000; sp_rm = 2'd0; sp_tag = 4'd9;
        repeat (3) @(negedge clk);
        chk("rst_pre_valid", {31'h0, sp_out_valid}, 32'd1);
        sp_out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'h0, sp_out_valid}, 32'd0);
        chk("rst_mid_res", sp_res, 32'd0);
        sp_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sp_out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (sp_out_valid) stale++;
        end
        chk("rst_no_stale", 32'(stale), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
